// File: rtl/etapa_if.sv
// etapa_if: instruction-fetch stage (IDLE/FETCH/HOLD) with a one-word hold buffer for stalls.
// Optional CNT_FETCH/CNT_STALL performance counters are added when ETAPA_IF_PERF_EN is defined.
module etapa_if (
    input  logic        reloj,
    input  logic        resetM,
    input  logic [1:0]  SEL_DIR,
    input  logic [31:0] BR_ADDR,
    input  logic [25:0] JUMP_ADDR,
    input  logic [31:0] JR_ADDR,
    input  logic        STALL,
    input  logic        IM_ACK,
    input  logic [31:0] IM_DATA,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    output logic [31:0] DO,
    output logic [3:0]  PC_4,
    output logic        IF_VALID
`ifdef ETAPA_IF_PERF_EN
    ,
    output logic [31:0] CNT_FETCH,
    output logic [31:0] CNT_STALL
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] do_reg, do_next;
    logic [31:0] hold_reg, hold_next;
    logic [3:0]  pc4_reg, pc4_next;
    logic        valid_reg, valid_next;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    logic        fetch_done;

    always_ff @(posedge reloj) begin
        if (!resetM) begin
            state_reg <= IDLE;
            pc_reg    <= 32'h0;
            do_reg    <= 32'h0;
            hold_reg  <= 32'h0;
            pc4_reg   <= 4'h0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            do_reg    <= do_next;
            hold_reg  <= hold_next;
            pc4_reg   <= pc4_next;
            valid_reg <= valid_next;
        end
    end

    // Next-PC select; every target is word aligned.
    always_comb begin
        pc_plus4 = pc_reg + 32'd4;
        redirect = (SEL_DIR != 2'b00);
        case (SEL_DIR)
            2'b00:   target = pc_plus4;
            2'b01:   target = {BR_ADDR[31:2], 2'b00};
            2'b10:   target = {pc_plus4[31:28], JUMP_ADDR, 2'b00};
            default: target = {JR_ADDR[31:2], 2'b00};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        do_next    = do_reg;
        hold_next  = hold_reg;
        pc4_next   = pc4_reg;
        valid_next = valid_reg;
        fetch_done = 1'b0;
        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (STALL) begin
                    if (IM_ACK) begin
                        hold_next  = IM_DATA;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    pc_next    = target;
                    do_next    = 32'h0;
                    valid_next = 1'b0;
                    pc4_next   = pc_plus4[31:28];
                end else if (IM_ACK) begin
                    pc_next    = target;
                    do_next    = IM_DATA;
                    valid_next = 1'b1;
                    pc4_next   = pc_plus4[31:28];
                    fetch_done = 1'b1;
                end else begin
                    do_next    = 32'h0;
                    valid_next = 1'b0;
                    pc4_next   = pc_plus4[31:28];
                end
            end
            HOLD: begin
                // PC still addresses the buffered word until the stall clears.
                if (!STALL) begin
                    state_next = FETCH;
                    hold_next  = 32'h0;
                    pc_next    = target;
                    pc4_next   = pc_plus4[31:28];
                    if (redirect) begin
                        do_next    = 32'h0;
                        valid_next = 1'b0;
                    end else begin
                        do_next    = hold_reg;
                        valid_next = 1'b1;
                        fetch_done = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        IM_REQ   = (state_reg == FETCH);
        IM_ADDR  = pc_reg;
        DO       = do_reg;
        PC_4     = pc4_reg;
        IF_VALID = valid_reg;
    end

`ifdef ETAPA_IF_PERF_EN
    logic [31:0] cnt_fetch_reg;
    logic [31:0] cnt_stall_reg;

    always_ff @(posedge reloj) begin
        if (!resetM) begin
            cnt_fetch_reg <= 32'h0;
            cnt_stall_reg <= 32'h0;
        end else begin
            if (fetch_done) cnt_fetch_reg <= cnt_fetch_reg + 32'd1;
            if (STALL)      cnt_stall_reg <= cnt_stall_reg + 32'd1;
        end
    end

    assign CNT_FETCH = cnt_fetch_reg;
    assign CNT_STALL = cnt_stall_reg;
`endif

endmodule
